div_sequencer: RTL and testbench

Multi-cycle signed/unsigned 32-bit integer divider controller for the Mini-SRC ALU. It runs restoring division by sequencing the shared 32-bit adder/subtractor: operand negation, 32 trial subtractions and result sign correction all go through that adder. It sits between the control unit, which issues DIV and waits on `done`, and the HI/LO register load path. The remainder goes to HI and the quotient to LO.

---
 rtl/div_sequencer.sv | 164 ++++++++++++++++
 tb/tb_div_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle signed/unsigned 32-bit restoring divider sequencing a shared adder
module div_sequencer (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_mode,
    input  logic [31:0] add_result
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS_A = 3'd1,
        ABS_B = 3'd2,
        DIV   = 3'd3,
        FIX_Q = 3'd4,
        FIX_R = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] a_reg;     // latched dividend (sign bit drives the fix-ups)
    logic [31:0] b_reg;     // latched divisor
    logic        sgn;       // latched is_signed
    logic [31:0] abs_b;     // |divisor|
    logic [31:0] r_reg;     // partial remainder
    logic [31:0] q_reg;     // |dividend| shifting out, quotient bits shifting in
    logic [4:0]  cnt;       // iteration counter for the 32 DIV steps

    // Restoring step: the bit shifted out of R means the true shift value
    // exceeds 2^32, so it is always at least the divisor.
    logic [31:0] shift;
    logic        msb;
    logic        qbit;
    assign shift = {r_reg[30:0], q_reg[31]};
    assign msb   = r_reg[31];
    assign qbit  = msb | (shift >= abs_b);

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and shared adder operand selection
    always_comb begin
        state_nxt = state;
        add_a     = 32'd0;
        add_b     = 32'd0;
        add_mode  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (divisor == 32'd0) ? DONE : ABS_A;
                end
            end
            ABS_A: begin
                add_b     = a_reg;
                add_mode  = sgn & a_reg[31];
                state_nxt = ABS_B;
            end
            ABS_B: begin
                add_b     = b_reg;
                add_mode  = sgn & b_reg[31];
                state_nxt = DIV;
            end
            DIV: begin
                add_a    = shift;
                add_b    = abs_b;
                add_mode = 1'b1;
                if (cnt == 5'd31) begin
                    state_nxt = FIX_Q;
                end
            end
            FIX_Q: begin
                add_b     = q_reg;
                add_mode  = sgn & (a_reg[31] ^ b_reg[31]);
                state_nxt = FIX_R;
            end
            FIX_R: begin
                add_b     = r_reg;
                add_mode  = sgn & a_reg[31];
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers: operand capture, magnitudes, iteration, results
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_reg       <= 32'd0;
            b_reg       <= 32'd0;
            sgn         <= 1'b0;
            abs_b       <= 32'd0;
            r_reg       <= 32'd0;
            q_reg       <= 32'd0;
            cnt         <= 5'd0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= dividend;
                        b_reg <= divisor;
                        sgn   <= is_signed;
                        if (divisor == 32'd0) begin
                            quotient    <= 32'hFFFF_FFFF;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                ABS_A: begin
                    q_reg <= add_result;
                end
                ABS_B: begin
                    abs_b <= add_result;
                    r_reg <= 32'd0;
                    cnt   <= 5'd0;
                end
                DIV: begin
                    r_reg <= qbit ? add_result : shift;
                    q_reg <= {q_reg[30:0], qbit};
                    cnt   <= cnt + 5'd1;
                end
                FIX_Q: begin
                    quotient <= add_result;
                end
                FIX_R: begin
                    remainder <= add_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - randomized self-checking bench for div_sequencer against an arithmetic reference
module tb_div_sequencer;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_mode;
    logic [31:0] add_result;

    int n_vec = 0;
    int n_err = 0;

    div_sequencer dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .quotient   (quotient),
        .remainder  (remainder),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_mode   (add_mode),
        .add_result (add_result)
    );

    // Shared ALU adder/subtractor
    assign add_result = add_mode ? (add_a - add_b) : (add_a + add_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, truncating toward zero
    function automatic void ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb;
        logic [63:0] tq, tr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[31:0];
            r  = tr[31:0];
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_dbz"},  {31'd0, div_by_zero}, 32'd0);
        check({tag, "_q"},    quotient, 32'd0);
        check({tag, "_r"},    remainder, 32'd0);
        check({tag, "_adda"}, add_a, 32'd0);
        check({tag, "_addb"}, add_b, 32'd0);
        check({tag, "_mode"}, {31'd0, add_mode}, 32'd0);
    endtask

    // One operation; inj > 0 pulses an extra start in that cycle with other operands
    task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                          input int inj, input string tag);
        logic [31:0] eq, er;
        logic        ez;
        int          lat;
        bit          got;
        ref_div(sg, a, b, eq, er, ez);
        lat = (b == 32'd0) ? 1 : 37;
        @(negedge clk);
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        got = 1'b0;
        for (int k = 1; k <= 60 && !got; k++) begin
            if (k > 1) @(negedge clk);
            start     = 1'b0;
            dividend  = $urandom;
            divisor   = $urandom | 32'd1;
            is_signed = ~sg;
            if (k == 2 && lat > 2) begin
                check({tag, "_absb_adda"}, add_a, 32'd0);
            end
            if (k == inj) start = 1'b1;
            if (done) begin
                got = 1'b1;
                check({tag, "_latency"}, k, lat);
                check({tag, "_q"}, quotient, eq);
                check({tag, "_r"}, remainder, er);
                check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
                check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
            end else if (k < lat) begin
                if (busy !== 1'b1) check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            end
        end
        start = 1'b0;
        if (!got) check({tag, "_done_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_adda"}, add_a | add_b | {31'd0, add_mode}, 32'd0);
        check({tag, "_hold_q"}, quotient, eq);
        check({tag, "_hold_r"}, remainder, er);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: pick = 32'd0;
            1: pick = 32'd1;
            2: pick = 32'hFFFF_FFFF;
            3: pick = 32'h8000_0000;
            4: pick = $urandom_range(0, 255);
            5: pick = -$urandom_range(1, 255);
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        bit seen_done;
        clr_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        clr_n = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, 0, "u100_7");
        run_op(1'b1, -32'd100, 32'd7, 0, "s-100_7");
        run_op(1'b1, 32'd100, -32'd7, 0, "s100_-7");
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, "umax_1");
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "umax_msb");
        run_op(1'b0, 32'd1234, 32'd0, 0, "dbz");
        run_op(1'b0, 32'd8, 32'd2, 0, "after_dbz");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 10, "min_m1");

        // Reset in cycle 20 of 50 / 3 aborts the operation
        @(negedge clk);
        is_signed = 1'b0;
        dividend  = 32'd50;
        divisor   = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        clr_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        clr_n = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        run_op(1'b0, 32'd50, 32'd3, 0, "restart_50_3");

        for (int i = 0; i < 30; i++) begin
            run_op(1'($urandom_range(0, 1)), pick(), pick(), 0, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
